// File: rtl/dds_pkg.sv
// Shared types, frame geometry and ramp-direction helper for the DDS frame scheduler.
package dds_pkg;

    localparam int FRAME_W  = 184;
    localparam int INIT_W   = 232;
    localparam int CNT_W    = 10;
    localparam int DR_S_LO  = 8;
    localparam int DR_S_HI  = 39;
    localparam int DR_E_LO  = 40;
    localparam int DR_E_HI  = 71;
    localparam int DR_FW    = DR_S_HI - DR_S_LO + 1;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RST_PULSE  = 4'd1,
        ST_RST_WAIT   = 4'd2,
        ST_START      = 4'd3,
        ST_SHIFT_WAIT = 4'd4,
        ST_UPD_WAIT   = 4'd5,
        ST_UPD_PULSE  = 4'd6,
        ST_DR_WAIT    = 4'd7,
        ST_DR_PULSE   = 4'd8,
        ST_HOLD       = 4'd9,
        ST_ABORT      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        DIR_EQ   = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dr_dir_e;

    // Fields are shifted LSB-first, so the lowest frame bit of each field is its MSB.
    function automatic dr_dir_e dr_dir(input logic [2*DR_FW-1:0] fld);
        logic [DR_FW-1:0] s_v;
        logic [DR_FW-1:0] e_v;
        for (int i = 0; i < DR_FW; i++) begin
            s_v[DR_FW-1-i] = fld[i];
            e_v[DR_FW-1-i] = fld[(DR_E_LO - DR_S_LO) + i];
        end
        if (s_v > e_v) begin
            return DIR_DOWN;
        end else if (s_v < e_v) begin
            return DIR_UP;
        end else begin
            return DIR_EQ;
        end
    endfunction

endpackage

// File: rtl/dds_req_sync.sv
// Request capture: 2-FF synchronizer, rising-edge detect and sticky pending flag.
module dds_req_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic clr,
    output logic pend
);

    logic [2:0] sync_r;
    logic       pend_r;
    logic       edge_s;

    // Two synchronizer stages plus one history stage for the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], req};
        end
    end

    assign edge_s = sync_r[1] & ~sync_r[2];

    // A fresh edge wins over a same-cycle clear so no request is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
        end else if (edge_s) begin
            pend_r <= 1'b1;
        end else if (clr) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    assign pend = pend_r;

endmodule

// File: rtl/dds_frame_scheduler.sv
// Arbitrates init/sweep frames onto the shared serial writer and sequences
// IO_RESET, IO_UPDATE and DR_CTL around each frame.
module dds_frame_scheduler
    import dds_pkg::*;
#(
    parameter int UPD_DELAY = 49,
    parameter int PULSE_LEN = 5,
    parameter int RST_GAP   = 48,
    parameter int DR_DELAY  = 19,
    parameter int HOLDOFF   = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic               ten_MHz_ext,
    input  logic               rst_n,
    input  logic               init_req,
    input  logic               sweep_req,
    input  logic [FRAME_W-1:0] sweep_frame,
    output logic               ser_start,
    output logic               ser_sel,
    output logic [FRAME_W-1:0] ser_frame,
    input  logic               ser_done,
    output logic               IO_RESET,
    output logic               IO_UPDATE,
    output logic               DR_CTL,
    output logic               init_done,
    output logic               busy,
    output logic               fault
);

    localparam logic [CNT_W-1:0] ZERO_LD  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(RST_GAP - 1);
    localparam logic [CNT_W-1:0] UPD_LD   = CNT_W'(UPD_DELAY - 1);
    localparam logic [CNT_W-1:0] DR_LD    = CNT_W'(DR_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT);

    state_e             state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r, next_cnt_s;
    logic               cnt_zero_s;
    logic               init_pend_s, sweep_pend_s;
    logic               grant_init_s, grant_sweep_s, done_set_s, fault_set_s;
    logic               sel_r, init_done_r, fault_r, dr_ctl_r;
    logic [FRAME_W-1:0] frame_r;
    logic               ser_start_r, io_reset_r, io_update_r, busy_r;
    dr_dir_e            dr_dir_s;
    logic               dr_rest_s, dr_pulse_s;

    dds_req_sync u_init_sync (
        .clk   (ten_MHz_ext),
        .rst_n (rst_n),
        .req   (init_req),
        .clr   (grant_init_s),
        .pend  (init_pend_s)
    );

    dds_req_sync u_sweep_sync (
        .clk   (ten_MHz_ext),
        .rst_n (rst_n),
        .req   (sweep_req),
        .clr   (grant_sweep_s),
        .pend  (sweep_pend_s)
    );

    assign cnt_zero_s = (cnt_r == ZERO_LD);

    // Next-state, counter reload on state entry, and grant/flag strobes.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_zero_s ? cnt_r : (cnt_r - {{(CNT_W-1){1'b0}}, 1'b1});
        grant_init_s  = 1'b0;
        grant_sweep_s = 1'b0;
        done_set_s    = 1'b0;
        fault_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (init_pend_s) begin
                    grant_init_s = 1'b1;
                    next_state_s = ST_RST_PULSE;
                    next_cnt_s   = PULSE_LD;
                end else if (sweep_pend_s && init_done_r) begin
                    grant_sweep_s = 1'b1;
                    next_state_s  = ST_START;
                    next_cnt_s    = ZERO_LD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RST_PULSE: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_RST_WAIT;
                    next_cnt_s   = GAP_LD;
                end else begin
                    next_state_s = ST_RST_PULSE;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_START;
                    next_cnt_s   = ZERO_LD;
                end else begin
                    next_state_s = ST_RST_WAIT;
                end
            end
            ST_START: begin
                next_state_s = ST_SHIFT_WAIT;
                next_cnt_s   = TO_LD;
            end
            ST_SHIFT_WAIT: begin
                if (ser_done) begin
                    next_state_s = ST_UPD_WAIT;
                    next_cnt_s   = UPD_LD;
                end else if (cnt_zero_s) begin
                    fault_set_s  = 1'b1;
                    next_state_s = ST_ABORT;
                    next_cnt_s   = PULSE_LD;
                end else begin
                    next_state_s = ST_SHIFT_WAIT;
                end
            end
            ST_UPD_WAIT: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_UPD_PULSE;
                    next_cnt_s   = PULSE_LD;
                end else begin
                    next_state_s = ST_UPD_WAIT;
                end
            end
            ST_UPD_PULSE: begin
                if (cnt_zero_s && sel_r) begin
                    next_state_s = ST_DR_WAIT;
                    next_cnt_s   = DR_LD;
                end else if (cnt_zero_s) begin
                    done_set_s   = 1'b1;
                    next_state_s = ST_HOLD;
                    next_cnt_s   = HOLD_LD;
                end else begin
                    next_state_s = ST_UPD_PULSE;
                end
            end
            ST_DR_WAIT: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_DR_PULSE;
                    next_cnt_s   = PULSE_LD;
                end else begin
                    next_state_s = ST_DR_WAIT;
                end
            end
            ST_DR_PULSE, ST_ABORT: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_HOLD;
                    next_cnt_s   = HOLD_LD;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_HOLD: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_IDLE;
                    next_cnt_s   = ZERO_LD;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = ZERO_LD;
            end
        endcase
    end

    // Ramp rest/pulse levels from the latched S/E fields; equal fields leave DR_CTL alone.
    always_comb begin
        dr_dir_s   = dr_dir(frame_r[DR_E_HI:DR_S_LO]);
        dr_rest_s  = dr_ctl_r;
        dr_pulse_s = dr_ctl_r;
        case (dr_dir_s)
            DIR_DOWN: begin
                dr_rest_s  = 1'b1;
                dr_pulse_s = 1'b0;
            end
            DIR_UP: begin
                dr_rest_s  = 1'b0;
                dr_pulse_s = 1'b1;
            end
            default: begin
                dr_rest_s  = dr_ctl_r;
                dr_pulse_s = dr_ctl_r;
            end
        endcase
    end

    // State, counter and strobe outputs decoded from the next state so they align with state_r.
    always_ff @(posedge ten_MHz_ext or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= ZERO_LD;
            ser_start_r <= 1'b0;
            io_reset_r  <= 1'b0;
            io_update_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= next_cnt_s;
            ser_start_r <= (next_state_s == ST_START);
            io_reset_r  <= (next_state_s == ST_RST_PULSE) || (next_state_s == ST_ABORT);
            io_update_r <= (next_state_s == ST_UPD_PULSE);
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    // Grant-time latches and sticky status flags.
    always_ff @(posedge ten_MHz_ext or negedge rst_n) begin
        if (!rst_n) begin
            sel_r       <= 1'b0;
            frame_r     <= {FRAME_W{1'b0}};
            init_done_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            if (grant_sweep_s) begin
                sel_r   <= 1'b1;
                frame_r <= sweep_frame;
            end else if (grant_init_s) begin
                sel_r   <= 1'b0;
                frame_r <= frame_r;
            end else begin
                sel_r   <= sel_r;
                frame_r <= frame_r;
            end
            init_done_r <= init_done_r | done_set_s;
            if (fault_set_s) begin
                fault_r <= 1'b1;
            end else if (grant_init_s) begin
                fault_r <= 1'b0;
            end else begin
                fault_r <= fault_r;
            end
        end
    end

    // DR_CTL takes its rest level on entering and leaving the ramp pulse window.
    always_ff @(posedge ten_MHz_ext or negedge rst_n) begin
        if (!rst_n) begin
            dr_ctl_r <= 1'b0;
        end else if ((state_r == ST_UPD_PULSE && next_state_s == ST_DR_WAIT) ||
                     (state_r == ST_DR_PULSE && next_state_s == ST_HOLD)) begin
            dr_ctl_r <= dr_rest_s;
        end else if (state_r == ST_DR_WAIT && next_state_s == ST_DR_PULSE) begin
            dr_ctl_r <= dr_pulse_s;
        end else begin
            dr_ctl_r <= dr_ctl_r;
        end
    end

    assign ser_start = ser_start_r;
    assign ser_sel   = sel_r;
    assign ser_frame = frame_r;
    assign IO_RESET  = io_reset_r;
    assign IO_UPDATE = io_update_r;
    assign DR_CTL    = dr_ctl_r;
    assign init_done = init_done_r;
    assign busy      = busy_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_dds_frame_scheduler.sv
// Scoreboard bench for dds_frame_scheduler: grants checked by a monitor, timing by edge stamps.
module tb_dds_frame_scheduler;
    import dds_pkg::*;

    logic               ten_MHz_ext = 1'b0;
    logic               rst_n       = 1'b1;
    logic               init_req    = 1'b0;
    logic               sweep_req   = 1'b0;
    logic               ser_done    = 1'b0;
    logic [FRAME_W-1:0] sweep_frame = '0;
    logic               ser_start, ser_sel, IO_RESET, IO_UPDATE, DR_CTL, init_done, busy, fault;
    logic [FRAME_W-1:0] ser_frame;

    typedef struct {
        logic               sel;
        logic [FRAME_W-1:0] frame;
    } exp_t;

    exp_t exp_q[$];
    int   dr_edges[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0, done_cyc = 0, rst_rise = 0, rst_fall = 0;
    int   upd_rise = 0, upd_fall = 0, busy_fall = 0, fault_rise = 0;
    int   n_starts = 0, n_upd = 0;
    int   done_delay = 100;

    dds_frame_scheduler dut (
        .ten_MHz_ext (ten_MHz_ext),
        .rst_n       (rst_n),
        .init_req    (init_req),
        .sweep_req   (sweep_req),
        .sweep_frame (sweep_frame),
        .ser_start   (ser_start),
        .ser_sel     (ser_sel),
        .ser_frame   (ser_frame),
        .ser_done    (ser_done),
        .IO_RESET    (IO_RESET),
        .IO_UPDATE   (IO_UPDATE),
        .DR_CTL      (DR_CTL),
        .init_done   (init_done),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 ten_MHz_ext = ~ten_MHz_ext;

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic check_frame(input string nm, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic sel, input logic [FRAME_W-1:0] fr);
        exp_t e;
        e.sel   = sel;
        e.frame = fr;
        exp_q.push_back(e);
    endtask

    // S occupies frame bits 8..39 and E bits 40..71, each with its MSB at the lowest bit.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [31:0] s, input logic [31:0] e,
                                                      input logic [FRAME_W-1:0] fill);
        logic [FRAME_W-1:0] f;
        f = fill;
        for (int i = 0; i < 32; i++) begin
            f[8 + i]  = s[31 - i];
            f[40 + i] = e[31 - i];
        end
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge ten_MHz_ext);
    endtask

    task automatic wait_frames(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (!(n_starts >= target && !busy) && k < budget) begin
            @(negedge ten_MHz_ext);
            k++;
        end
        check_bit({nm, "_complete"}, (k < budget), 1'b1);
    endtask

    task automatic wait_busy(input string nm);
        int k;
        k = 0;
        while (!busy && k < 20) begin
            @(negedge ten_MHz_ext);
            k++;
        end
        check_bit({nm, "_grant"}, busy, 1'b1);
    endtask

    // Shifter model: answers ser_start with a one-cycle ser_done after done_delay cycles.
    initial begin : shifter
        forever begin
            @(negedge ten_MHz_ext);
            if (ser_start && done_delay >= 0) begin
                repeat (done_delay) @(negedge ten_MHz_ext);
                ser_done = 1'b1;
                @(negedge ten_MHz_ext);
                ser_done = 1'b0;
            end
        end
    end

    // Monitor: stamps output edges and pops the scoreboard on every ser_start.
    initial begin : monitor
        logic p_rst, p_upd, p_dr, p_busy, p_fault;
        exp_t e;
        p_rst = 1'b0; p_upd = 1'b0; p_dr = 1'b0; p_busy = 1'b0; p_fault = 1'b0;
        forever begin
            @(posedge ten_MHz_ext);
            #1;
            cyc++;
            if (IO_RESET && !p_rst) rst_rise = cyc;
            if (!IO_RESET && p_rst) rst_fall = cyc;
            if (IO_UPDATE && !p_upd) begin upd_rise = cyc; n_upd++; end
            if (!IO_UPDATE && p_upd) upd_fall = cyc;
            if (!busy && p_busy) busy_fall = cyc;
            if (fault && !p_fault) fault_rise = cyc;
            if (DR_CTL != p_dr) dr_edges.push_back(cyc);
            if (ser_done) done_cyc = cyc;
            if (ser_start) begin
                n_starts++;
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_start: unexpected ser_start with sel=%b, expected none", ser_sel);
                end else begin
                    e = exp_q.pop_front();
                    check_bit("sb_sel", ser_sel, e.sel);
                    if (e.sel) check_frame("sb_frame", ser_frame, e.frame);
                end
            end
            p_rst = IO_RESET; p_upd = IO_UPDATE; p_dr = DR_CTL; p_busy = busy; p_fault = fault;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [FRAME_W-1:0] f1, f2, f3, f4;
        int s0, u0;
        f1 = make_frame(32'h0000_0010, 32'h0000_0020, {23{8'h5A}});
        f2 = make_frame(32'h0000_0020, 32'h0000_0010, {23{8'hC3}});
        f3 = make_frame(32'h0000_0055, 32'h0000_0055, {23{8'h3C}});
        f4 = make_frame(32'h0000_0001, 32'hFFFF_FFFF, {23{8'h96}});

        #1 rst_n = 1'b0;
        tick(3);
        check_bit("rst_ser_start", ser_start, 1'b0);
        check_bit("rst_ser_sel", ser_sel, 1'b0);
        check_bit("rst_io_reset", IO_RESET, 1'b0);
        check_bit("rst_io_update", IO_UPDATE, 1'b0);
        check_bit("rst_dr_ctl", DR_CTL, 1'b0);
        check_bit("rst_init_done", init_done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_fault", fault, 1'b0);
        check_frame("rst_ser_frame", ser_frame, '0);
        rst_n = 1'b1;
        tick(2);

        // Init sequence timing.
        push_exp(1'b0, '0);
        init_req = 1'b1;
        wait_frames(1, 2000, "init1");
        init_req = 1'b0;
        check_int("init_rst_width", rst_fall - rst_rise, 5);
        check_int("init_rst_gap", start_cyc - rst_fall, 48);
        check_int("init_upd_delay", upd_rise - done_cyc, 49);
        check_int("init_upd_width", upd_fall - upd_rise, 5);
        check_int("init_holdoff", busy_fall - upd_fall, 16);
        check_bit("init_done_set", init_done, 1'b1);

        // Sweep before init is held off, then runs after init (S<E).
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        s0 = n_starts;
        sweep_frame = f1;
        sweep_req = 1'b1;
        tick(200);
        check_int("sweep_blocked", n_starts, s0);
        check_bit("sweep_blocked_busy", busy, 1'b0);
        push_exp(1'b0, '0);
        push_exp(1'b1, f1);
        dr_edges.delete();
        init_req = 1'b1;
        wait_frames(s0 + 2, 4000, "init_then_sweep");
        init_req = 1'b0;
        sweep_req = 1'b0;
        check_int("dr_up_edges", dr_edges.size(), 2);
        if (dr_edges.size() == 2) begin
            check_int("dr_up_rise", dr_edges[0] - upd_fall, 19);
            check_int("dr_up_fall", dr_edges[1] - upd_fall, 24);
        end
        check_bit("dr_up_final", DR_CTL, 1'b0);

        // S>E: rest level 1 on DR_WAIT entry, low pulse.
        tick(5);
        sweep_frame = f2;
        push_exp(1'b1, f2);
        dr_edges.delete();
        sweep_req = 1'b1;
        wait_frames(n_starts + 1, 2000, "sweep_down");
        sweep_req = 1'b0;
        check_int("dr_down_edges", dr_edges.size(), 3);
        if (dr_edges.size() == 3) begin
            check_int("dr_down_rest", dr_edges[0] - upd_fall, 0);
            check_int("dr_down_fall", dr_edges[1] - upd_fall, 19);
            check_int("dr_down_rise", dr_edges[2] - upd_fall, 24);
        end
        check_bit("dr_down_final", DR_CTL, 1'b1);

        // S==E: DR_CTL untouched.
        tick(5);
        sweep_frame = f3;
        push_exp(1'b1, f3);
        dr_edges.delete();
        sweep_req = 1'b1;
        wait_frames(n_starts + 1, 2000, "sweep_eq");
        sweep_req = 1'b0;
        check_int("dr_eq_edges", dr_edges.size(), 0);
        check_bit("dr_eq_final", DR_CTL, 1'b1);

        // Simultaneous requests: init first, sweep after holdoff.
        tick(5);
        sweep_frame = f4;
        push_exp(1'b0, '0);
        push_exp(1'b1, f4);
        s0 = n_starts;
        init_req = 1'b1;
        sweep_req = 1'b1;
        wait_frames(s0 + 2, 4000, "simul");
        init_req = 1'b0;
        sweep_req = 1'b0;
        check_int("simul_starts", n_starts - s0, 2);

        // Shifter timeout.
        tick(5);
        done_delay = -1;
        u0 = n_upd;
        push_exp(1'b0, '0);
        init_req = 1'b1;
        wait_frames(n_starts + 1, 3000, "timeout");
        init_req = 1'b0;
        check_bit("to_fault", fault, 1'b1);
        check_int("to_shift_cycles", fault_rise - start_cyc, 1025);
        check_int("to_rst_align", rst_rise, fault_rise);
        check_int("to_rst_width", rst_fall - rst_rise, 5);
        check_int("to_no_update", n_upd, u0);
        check_bit("to_init_done_kept", init_done, 1'b1);

        // Next init grant clears fault.
        tick(5);
        done_delay = 100;
        push_exp(1'b0, '0);
        init_req = 1'b1;
        wait_busy("fault_clear");
        check_bit("fault_cleared", fault, 1'b0);
        wait_frames(n_starts + 1, 2000, "recover");
        init_req = 1'b0;

        // Reset during IO_UPDATE with a pending init captured mid-frame.
        tick(5);
        push_exp(1'b0, '0);
        init_req = 1'b1;
        wait_busy("rst_mid");
        s0 = n_starts;
        init_req = 1'b0;
        tick(10);
        init_req = 1'b1;
        begin
            int k;
            k = 0;
            while (!IO_UPDATE && k < 1000) begin
                @(negedge ten_MHz_ext);
                k++;
            end
        end
        check_bit("rst_mid_in_update", IO_UPDATE, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("rst_mid_io_update", IO_UPDATE, 1'b0);
        check_bit("rst_mid_busy", busy, 1'b0);
        check_bit("rst_mid_init_done", init_done, 1'b0);
        tick(2);
        init_req = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(200);
        check_int("rst_mid_pend_cleared", n_starts, s0 + 1);
        check_bit("rst_mid_idle", busy, 1'b0);

        check_int("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
